// File: rtl/toaplan2_eeprom_pkg.sv
// rtl/toaplan2_eeprom_pkg.sv - shared types and constants for the 93C46 serial EEPROM responder
package toaplan2_eeprom_pkg;

  localparam int ADDR_W = 6;
  localparam int WORD_W = 16;
  localparam int WORDS  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_ADDR,
    ST_DATA_IN,
    ST_READ_OUT,
    ST_WAIT_CS,
    ST_BUSY
  } state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b11;
  localparam logic [1:0] OP_EXT   = 2'b00;

  // Extended sub-ops live in address bits [5:4] when the opcode is OP_EXT
  localparam logic [1:0] EXT_EWEN = 2'b11;
  localparam logic [1:0] EXT_EWDS = 2'b00;
  localparam logic [1:0] EXT_ERAL = 2'b10;
  localparam logic [1:0] EXT_WRAL = 2'b01;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_READ,
    CMD_WRITE,
    CMD_ERASE,
    CMD_ERAL,
    CMD_WRAL,
    CMD_EWEN,
    CMD_EWDS
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a);
    cmd_e c;
    c = CMD_NONE;
    case (op)
      OP_READ:  c = CMD_READ;
      OP_WRITE: c = CMD_WRITE;
      OP_ERASE: c = CMD_ERASE;
      default: begin
        case (a[5:4])
          EXT_EWEN: c = CMD_EWEN;
          EXT_EWDS: c = CMD_EWDS;
          EXT_ERAL: c = CMD_ERAL;
          default:  c = CMD_WRAL;
        endcase
      end
    endcase
    return c;
  endfunction

  // Commands that modify the array and therefore need WEN and a busy period
  function automatic logic is_program(input cmd_e c);
    return (c == CMD_WRITE) || (c == CMD_ERASE) || (c == CMD_ERAL) || (c == CMD_WRAL);
  endfunction

endpackage

// File: rtl/toaplan2_eeprom93c46_if.sv
// rtl/toaplan2_eeprom93c46_if.sv - Microwire serial lines between the 68K I/O latch and the EEPROM
interface toaplan2_eeprom93c46_if;
  logic SCS;
  logic SCLK;
  logic SDI;
  logic SDO;

  modport master (output SCS, output SCLK, output SDI, input SDO);
  modport slave  (input SCS, input SCLK, input SDI, output SDO);
endinterface

// File: rtl/toaplan2_eeprom_mem.sv
// rtl/toaplan2_eeprom_mem.sv - 64x16 word array, protocol port plus optional host dump port (EEPROM_NVRAM_EN)
module toaplan2_eeprom_mem
  import toaplan2_eeprom_pkg::*;
#(
  parameter logic [WORD_W-1:0] INIT_WORD = 16'hFFFF
) (
  input  logic              clk_i,
`ifdef EEPROM_NVRAM_EN
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] dump_addr_i,
  input  logic [WORD_W-1:0] dump_din_i,
  input  logic              dump_we_i,
  output logic [WORD_W-1:0] dump_dout_o,
`endif
  input  logic              proto_we_i,
  input  logic [ADDR_W-1:0] proto_waddr_i,
  input  logic [WORD_W-1:0] proto_wdata_i,
  input  logic [ADDR_W-1:0] proto_raddr_i,
  output logic [WORD_W-1:0] proto_rdata_o
);

  // Power-up content; reset deliberately leaves the array alone
  logic [WORD_W-1:0] mem_q [WORDS] = '{default: INIT_WORD};

  // Array writes: the protocol write is issued last so it wins a same-word collision
  always_ff @(posedge clk_i) begin
`ifdef EEPROM_NVRAM_EN
    if (dump_we_i) mem_q[dump_addr_i] <= dump_din_i;
`endif
    if (proto_we_i) mem_q[proto_waddr_i] <= proto_wdata_i;
  end

  assign proto_rdata_o = mem_q[proto_raddr_i];

`ifdef EEPROM_NVRAM_EN
  logic [WORD_W-1:0] dump_dout_q;

  // Registered host read port
  always_ff @(posedge clk_i) begin
    if (rst_i) dump_dout_q <= '0;
    else       dump_dout_q <= mem_q[dump_addr_i];
  end

  assign dump_dout_o = dump_dout_q;
`endif

endmodule

// File: rtl/toaplan2_eeprom93c46.sv
// rtl/toaplan2_eeprom93c46.sv - 93C46 Microwire EEPROM responder top; EEPROM_NVRAM_EN adds the host dump port
module toaplan2_eeprom93c46
  import toaplan2_eeprom_pkg::*;
#(
  parameter int                BUSY_CYCLES = 64,
  parameter logic [WORD_W-1:0] INIT_WORD   = 16'hFFFF
) (
  input  logic                          CLK,
  input  logic                          RESET,
  toaplan2_eeprom93c46_if.slave         bus
`ifdef EEPROM_NVRAM_EN
  ,
  input  logic [ADDR_W-1:0]             DUMP_ADDR,
  input  logic [WORD_W-1:0]             DUMP_DIN,
  input  logic                          DUMP_WE,
  output logic [WORD_W-1:0]             DUMP_DOUT
`endif
);

  // A zero busy time still passes through BUSY for one cycle; bulk ops need the full sweep
  localparam int SINGLE_CYCLES = (BUSY_CYCLES < 1) ? 1 : BUSY_CYCLES;
  localparam int BULK_CYCLES   = (BUSY_CYCLES < WORDS) ? WORDS : BUSY_CYCLES;
  localparam int BUSY_W        = $clog2(BULK_CYCLES + 1);

  state_e              state_q, state_d;
  logic                sclk_q;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  cmd_e                cmd_q, cmd_d;
  logic                wen_q, wen_d;
  logic                sdo_q, sdo_d;
  logic [BUSY_W-1:0]   busy_q, busy_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic                sweep_act_q, sweep_act_d;

  logic                sclk_rise;
  logic [ADDR_W-1:0]   shift_addr;
  cmd_e                dec_cmd;
  logic                pw_we;
  logic [ADDR_W-1:0]   pw_addr;
  logic [WORD_W-1:0]   pw_data;
  logic [WORD_W-1:0]   rd_data;

  assign sclk_rise  = bus.SCS && bus.SCLK && !sclk_q;
  assign shift_addr = {addr_q[ADDR_W-2:0], bus.SDI};
  assign dec_cmd    = decode_cmd(op_q, shift_addr);
  assign bus.SDO    = sdo_q;

  toaplan2_eeprom_mem #(
    .INIT_WORD (INIT_WORD)
  ) u_mem (
    .clk_i         (CLK),
`ifdef EEPROM_NVRAM_EN
    .rst_i         (RESET),
    .dump_addr_i   (DUMP_ADDR),
    .dump_din_i    (DUMP_DIN),
    .dump_we_i     (DUMP_WE),
    .dump_dout_o   (DUMP_DOUT),
`endif
    .proto_we_i    (pw_we),
    .proto_waddr_i (pw_addr),
    .proto_wdata_i (pw_data),
    .proto_raddr_i (addr_q),
    .proto_rdata_o (rd_data)
  );

  // State and shift registers; the array itself is not reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      sclk_q      <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cmd_q       <= CMD_NONE;
      wen_q       <= 1'b0;
      sdo_q       <= 1'b1;
      busy_q      <= '0;
      sweep_q     <= '0;
      sweep_act_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= bus.SCLK;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cmd_q       <= cmd_d;
      wen_q       <= wen_d;
      sdo_q       <= sdo_d;
      busy_q      <= busy_d;
      sweep_q     <= sweep_d;
      sweep_act_q <= sweep_act_d;
    end
  end

  // Command decode, serial shifting, commit and busy sweep
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cmd_d       = cmd_q;
    wen_d       = wen_q;
    sdo_d       = 1'b1;
    busy_d      = busy_q;
    sweep_d     = sweep_q;
    sweep_act_d = sweep_act_q;
    pw_we       = 1'b0;
    pw_addr     = addr_q;
    pw_data     = data_q;

    if (state_q == ST_BUSY) begin
      // Chip select has no effect here; SDO reports busy only while selected
      sdo_d = !bus.SCS;
      if (sweep_act_q) begin
        pw_we   = 1'b1;
        pw_addr = sweep_q;
        sweep_d = sweep_q + 6'd1;
        if (sweep_q == 6'd63) sweep_act_d = 1'b0;
      end
      if (busy_q <= BUSY_W'(1)) begin
        state_d = ST_IDLE;
        busy_d  = '0;
      end else begin
        busy_d = busy_q - BUSY_W'(1);
      end
    end else if (!bus.SCS) begin
      // Deselect aborts anything short of WAIT_CS; from WAIT_CS it commits a program op
      state_d = ST_IDLE;
      cnt_d   = '0;
      op_d    = '0;
      addr_d  = '0;
      data_d  = '0;
      cmd_d   = CMD_NONE;
      if (state_q == ST_WAIT_CS && wen_q && is_program(cmd_q)) begin
        state_d = ST_BUSY;
        busy_d  = BUSY_W'(SINGLE_CYCLES);
        case (cmd_q)
          CMD_WRITE: pw_we = 1'b1;
          CMD_ERASE: begin
            pw_we   = 1'b1;
            pw_data = '1;
          end
          default: begin
            busy_d      = BUSY_W'(BULK_CYCLES);
            sweep_d     = '0;
            sweep_act_d = 1'b1;
            data_d      = (cmd_q == CMD_ERAL) ? '1 : data_q;
          end
        endcase
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sclk_rise && bus.SDI) begin
            state_d = ST_OPC;
            cnt_d   = '0;
            cmd_d   = CMD_NONE;
          end
        end
        ST_OPC: begin
          if (sclk_rise) begin
            op_d = {op_q[0], bus.SDI};
            if (cnt_q == 4'd1) begin
              cnt_d   = '0;
              state_d = ST_ADDR;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            addr_d = shift_addr;
            if (cnt_q == 4'd5) begin
              cnt_d = '0;
              cmd_d = dec_cmd;
              case (dec_cmd)
                CMD_READ: begin
                  state_d = ST_READ_OUT;
                  sdo_d   = 1'b0;
                end
                CMD_WRITE, CMD_WRAL: state_d = ST_DATA_IN;
                CMD_EWEN: begin
                  wen_d   = 1'b1;
                  state_d = ST_WAIT_CS;
                end
                CMD_EWDS: begin
                  wen_d   = 1'b0;
                  state_d = ST_WAIT_CS;
                end
                default: state_d = ST_WAIT_CS;
              endcase
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ST_DATA_IN: begin
          if (sclk_rise) begin
            data_d = {data_q[WORD_W-2:0], bus.SDI};
            if (cnt_q == 4'd15) begin
              cnt_d   = '0;
              state_d = ST_WAIT_CS;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ST_READ_OUT: begin
          // Stream MSB first; roll to the next word without a dummy bit
          sdo_d = sdo_q;
          if (sclk_rise) begin
            sdo_d = rd_data[~cnt_q];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) addr_d = addr_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toaplan2_eeprom93c46.sv
// tb/tb_toaplan2_eeprom93c46.sv - directed self-checking bench for the 93C46 EEPROM responder
module tb_toaplan2_eeprom93c46;

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_errors;

  toaplan2_eeprom93c46_if bus ();

`ifdef EEPROM_NVRAM_EN
  logic [5:0]  dump_addr;
  logic [15:0] dump_din;
  logic        dump_we;
  logic [15:0] dump_dout;
`endif

  toaplan2_eeprom93c46 #(
    .BUSY_CYCLES (64),
    .INIT_WORD   (16'hFFFF)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus)
`ifdef EEPROM_NVRAM_EN
    ,
    .DUMP_ADDR (dump_addr),
    .DUMP_DIN  (dump_din),
    .DUMP_WE   (dump_we),
    .DUMP_DOUT (dump_dout)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One serial bit: SDI setup, SCLK high, sample SDO after the DUT has reacted
  task automatic sbit(input logic b, output logic o);
    @(negedge CLK); bus.SDI = b;
    @(negedge CLK); bus.SCLK = 1'b1;
    @(negedge CLK);
    @(negedge CLK); o = bus.SDO; bus.SCLK = 1'b0;
  endtask

  task automatic send_hdr(input logic [1:0] op, input logic [5:0] a, output logic last);
    logic o;
    @(negedge CLK); bus.SCS = 1'b1;
    sbit(1'b1, o);
    sbit(op[1], o);
    sbit(op[0], o);
    for (int i = 5; i >= 0; i--) sbit(a[i], o);
    last = o;
  endtask

  task automatic send_data(input logic [15:0] d);
    logic o;
    for (int i = 15; i >= 0; i--) sbit(d[i], o);
  endtask

  // Deselect (commit point), reselect and count busy cycles on SDO, then deselect
  task automatic end_cmd(output int zeros);
    zeros = 0;
    @(negedge CLK); bus.SCS = 1'b0;
    @(negedge CLK); bus.SCS = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (bus.SDO === 1'b1) break;
      zeros++;
    end
    @(negedge CLK); bus.SCS = 1'b0;
    @(negedge CLK);
  endtask

  task automatic do_read(input logic [5:0] a, output logic dmy, output logic [15:0] w0,
                         output logic [15:0] w1, output logic after);
    logic o;
    send_hdr(2'b10, a, dmy);
    for (int i = 0; i < 16; i++) begin sbit(1'b0, o); w0 = {w0[14:0], o}; end
    for (int i = 0; i < 16; i++) begin sbit(1'b0, o); w1 = {w1[14:0], o}; end
    @(negedge CLK); bus.SCS = 1'b0;
    @(negedge CLK); after = bus.SDO;
  endtask

  initial begin
    logic        dmy, after, o;
    logic [15:0] w0, w1;
    int          z;

    n_checks = 0;
    n_errors = 0;
    RESET    = 1'b1;
    bus.SCS  = 1'b0;
    bus.SCLK = 1'b0;
    bus.SDI  = 1'b0;
`ifdef EEPROM_NVRAM_EN
    dump_addr = '0;
    dump_din  = '0;
    dump_we   = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("reset_sdo", bus.SDO, 1'b1);

    // Fresh array: READ 0x3F streams FFFF then wraps to 0x00
    do_read(6'h3F, dmy, w0, w1, after);
    check("rd3f_dummy", dmy, 1'b0);
    check("rd3f_w0", w0, 16'hFFFF);
    check("rd3f_w1", w1, 16'hFFFF);
    check("rd3f_after", after, 1'b1);

    // EWEN then WRITE 0x05 = 0x1234
    send_hdr(2'b00, 6'b110000, o); end_cmd(z);
    check("ewen_busy", z, 0);
    send_hdr(2'b01, 6'h05, o); send_data(16'h1234); end_cmd(z);
    check("write05_busy", z, 64);
    do_read(6'h05, dmy, w0, w1, after);
    check("rd05_dummy", dmy, 1'b0);
    check("rd05_w0", w0, 16'h1234);
    check("rd06_w1", w1, 16'hFFFF);

    // EWDS blocks the next WRITE
    send_hdr(2'b00, 6'b000000, o); end_cmd(z);
    check("ewds_busy", z, 0);
    send_hdr(2'b01, 6'h05, o); send_data(16'hABCD); end_cmd(z);
    check("write_dis_busy", z, 0);
    do_read(6'h05, dmy, w0, w1, after);
    check("rd05_kept", w0, 16'h1234);

    // WRITE aborted after three address bits leaves the word alone
    send_hdr(2'b00, 6'b110000, o); end_cmd(z);
    @(negedge CLK); bus.SCS = 1'b1;
    sbit(1'b1, o); sbit(1'b0, o); sbit(1'b1, o);
    sbit(1'b0, o); sbit(1'b0, o); sbit(1'b0, o);
    @(negedge CLK); bus.SCS = 1'b0;
    @(negedge CLK);
    do_read(6'h05, dmy, w0, w1, after);
    check("abort_dummy", dmy, 1'b0);
    check("abort_w0", w0, 16'h1234);

    // WRAL 0x5A5A, then read across the 0x3F -> 0x00 wrap
    send_hdr(2'b00, 6'b010000, o); send_data(16'h5A5A); end_cmd(z);
    check("wral_busy", z, 64);
    do_read(6'h3F, dmy, w0, w1, after);
    check("wral_dummy", dmy, 1'b0);
    check("wral_w3f", w0, 16'h5A5A);
    check("wral_w00", w1, 16'h5A5A);
    check("wral_after", after, 1'b1);

    // ERAL returns everything to FFFF
    send_hdr(2'b00, 6'b100000, o); end_cmd(z);
    check("eral_busy", z, 64);
    do_read(6'h3F, dmy, w0, w1, after);
    check("eral_w3f", w0, 16'hFFFF);
    check("eral_w00", w1, 16'hFFFF);
    do_read(6'h05, dmy, w0, w1, after);
    check("eral_w05", w0, 16'hFFFF);

    // RESET during BUSY: single word already written, WEN cleared
    send_hdr(2'b01, 6'h10, o); send_data(16'h0F0F);
    @(negedge CLK); bus.SCS = 1'b0;
    @(negedge CLK); bus.SCS = 1'b1;
    repeat (10) @(negedge CLK);
    check("midbusy_sdo", bus.SDO, 1'b0);
    RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    check("rst_sdo", bus.SDO, 1'b1);
    @(negedge CLK);
    check("rst_idle_sdo", bus.SDO, 1'b1);
    bus.SCS = 1'b0;
    @(negedge CLK);
    send_hdr(2'b01, 6'h11, o); send_data(16'h1111); end_cmd(z);
    check("rst_wen_busy", z, 0);
    do_read(6'h10, dmy, w0, w1, after);
    check("rst_w10", w0, 16'h0F0F);
    check("rst_w11", w1, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/toaplan2_eeprom93c46.md
# toaplan2_eeprom93c46

Cycle-accurate behavioural responder for the 93C46-style 64×16 serial EEPROM that stores high scores and settings on the Toaplan2/Raizing boards. The 68K side bit-bangs chip select, serial clock and serial data through an I/O latch. This block is the device at the other end: it decodes the Microwire command stream, holds the 64-word array and drives the serial data-out line back to the CPU input port. It sits beside the game's CPU block in the 48 MHz domain, wired to the board's EEPROM_SCS, EEPROM_SCLK, EEPROM_SDI and EEPROM_SDO nets.

## Interface
Parameters:
- BUSY_CYCLES, 64: CLK cycles that SDO reads busy (0) after a program or erase command commits.
- INIT_WORD, 16'hFFFF: power-up content of every word.

Ports:
- CLK  in  1  48 MHz system clock. One clock; reset is synchronous and active-high.
- RESET  in  1  synchronous, active-high.
- SCS  in  1  chip select, active high.
- SCLK  in  1  serial clock. Level-sampled on CLK.
- SDI  in  1  serial data from the CPU.
- SDO  out  1  serial data and status to the CPU. Reads 1 when not driven.
- DUMP_ADDR  in  6  host word address (EEPROM_NVRAM_EN only).
- DUMP_DIN  in  16  host write data (EEPROM_NVRAM_EN only).
- DUMP_WE  in  1  host word write strobe (EEPROM_NVRAM_EN only).
- DUMP_DOUT  out  16  host read data, 1-cycle latency (EEPROM_NVRAM_EN only).

## Operation
- SCLK rising edge: registered previous SCLK is 0 and current SCLK is 1. All protocol actions occur only on a detected edge while SCS = 1.
- States:
  - IDLE: waits for the start bit (SDI = 1 on an edge). Leading zeros are ignored.
  - OPC: captures 2 opcode bits.
  - ADDR: captures 6 address bits, MSB first.
  - DATA_IN: captures 16 data bits (WRITE and WRAL only).
  - READ_OUT: shifts data out.
  - WAIT_CS: command is complete; waits for SCS to fall.
  - BUSY: self-timed programming in progress.
- Opcodes:
  - 10 READ
  - 01 WRITE
  - 11 ERASE (word becomes FFFF)
  - 00 extended, selected by address bits [5:4]:
    - 11 EWEN
    - 00 EWDS
    - 10 ERAL (all words FFFF)
    - 01 WRAL (all words get the data)
- Write enable latch (WEN): set by EWEN, cleared by EWDS. Reset value 0. WRITE, ERASE, ERAL and WRAL with WEN = 0 are decoded and then silently discarded; no busy period follows.
- READ:
  - The edge that captures A0 drives SDO = 0 (dummy bit).
  - Each following edge outputs D15..D0 of the addressed word.
  - After D0, the address increments modulo 64 and the next word streams out with no dummy bit (sequential read, 0x3F wraps to 0x00).
- Program commit: on SCS falling in WAIT_CS for a program/erase command with WEN = 1.
  - The array update happens in that cycle. ERAL/WRAL use a 64-cycle sweep inside BUSY.
  - The block then enters BUSY for BUSY_CYCLES cycles, or max(BUSY_CYCLES, 64) for ERAL/WRAL.
- SDO rules:
  - In BUSY with SCS = 1: SDO = 0.
  - After BUSY ends, with SCS = 1: SDO = 1 (ready).
  - All other non-READ_OUT cases: SDO = 1.
- SCS low in any state except BUSY: return to IDLE, clear shift and bit counters, SDO = 1. A command aborted before WAIT_CS has no effect.
- Edges during BUSY are ignored. A start bit is accepted only after returning to IDLE.

## Timing
- Edge detection latency is 1 CLK. SDO updates on the CLK following the detected edge. The CPU samples only after its own delay, so this latency is always satisfied.
- Reset values:
  - SDO = 1, state IDLE, WEN = 0.
  - Counters = 0, busy counter = 0.
  - DUMP_DOUT = 0.
- RESET does not alter array contents. The array powers up to INIT_WORD.
- RESET asserted during BUSY aborts the busy period. A single-word write has already committed. An ERAL/WRAL sweep stops partway.
- Bit counters: 2, 6, 16 and 4-bit read counters wrap exactly. Address arithmetic is 6-bit modulo.
- Simultaneous DUMP_WE and a protocol write to the same word in the same cycle: the protocol write wins.

## Configuration
- EEPROM_NVRAM_EN defined: the DUMP_* ports exist. This gives the host/loader a second array port for NVRAM save/restore. DUMP_DOUT returns mem[DUMP_ADDR] registered.
- EEPROM_NVRAM_EN undefined: the DUMP_* ports and their logic are absent. The array is serial-only and volatile across power cycles.

## Structure
- Package toaplan2_eeprom_pkg:
  - State enum.
  - Opcode constants (OP_READ, OP_WRITE, OP_ERASE, OP_EXT).
  - Extended sub-op constants.
  - ADDR_W = 6, WORD_W = 16.
- Sub-module toaplan2_eeprom_mem: 64×16 array with a protocol port and the optional dump port. The protocol port has write priority.

## Test plan
- After reset, READ 0x3F → dummy 0 then 0xFFFF on SDO; SDO = 1 after SCS falls.
- EWEN, then WRITE 0x05 = 0x1234 → SDO = 0 for 64 CLK with SCS high, then 1. READ 0x05 → 0x1234.
- EWDS, then WRITE 0x05 = 0xABCD → no busy period. READ 0x05 still returns 0x1234.
- EWEN, then WRAL 0x5A5A → READ 0x3F streams 0x5A5A then wraps to 0x00 with 0x5A5A. ERAL → all words 0xFFFF.
- SCS dropped after 3 address bits of a WRITE → no change. The next READ decodes correctly from a fresh start bit.
- RESET pulsed mid-BUSY after WRITE 0x10 = 0x0F0F → SDO = 1, WEN = 0, READ 0x10 returns 0x0F0F.
